// File: rtl/lcd_ctrl_if.sv
// LSU-side LCD register strobe, LCD pad bus and status bundle.
// The slave modport is the controller's view; master is the LSU/board view.
`timescale 1ns/1ps
interface lcd_ctrl_if;
    logic [31:0] i_lcd;
    logic        i_lcd_vld;
    logic [7:0]  i_lcd_data;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_data_oe;
    logic        o_lcd_en;
    logic        o_lcd_rs;
    logic        o_lcd_rw;
    logic        o_lcd_on;
    logic        o_lcd_blon;
    logic        o_busy;
    logic        o_drop;
    logic [7:0]  o_rd_data;
    logic        o_rd_vld;

    modport master (
        output i_lcd, i_lcd_vld, i_lcd_data,
        input  o_lcd_data, o_lcd_data_oe, o_lcd_en, o_lcd_rs, o_lcd_rw,
        input  o_lcd_on, o_lcd_blon, o_busy, o_drop, o_rd_data, o_rd_vld
    );

    modport slave (
        input  i_lcd, i_lcd_vld, i_lcd_data,
        output o_lcd_data, o_lcd_data_oe, o_lcd_en, o_lcd_rs, o_lcd_rw,
        output o_lcd_on, o_lcd_blon, o_busy, o_drop, o_rd_data, o_rd_vld
    );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780 bus sequencer: setup, EN pulse, hold, execution wait per LCD write.
// LCD_CTRL_PENDING_EN adds a one-entry slot for writes arriving while busy.
`timescale 1ns/1ps
module lcd_ctrl #(
    parameter int T_SETUP      = 2,
    parameter int T_PULSE      = 12,
    parameter int T_HOLD       = 2,
    parameter int T_EXEC_SHORT = 2000,
    parameter int T_EXEC_LONG  = 82000
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    lcd_ctrl_if.slave bus
);

    localparam int TMAX = (T_EXEC_LONG > T_EXEC_SHORT) ? T_EXEC_LONG : T_EXEC_SHORT;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_SHORT = CW'(T_EXEC_SHORT - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(T_EXEC_LONG - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic [7:0] act_data;
    logic       act_rs;
    logic       act_rw;

    logic [9:0] in_word;
    logic       done;
    logic       is_long;
    logic       drive;
    logic       take_new;
    logic       take_pend;
    logic       finish;
    logic       cap;
    logic       drop;
    logic       pend_vld;

    logic       drop_q;
    logic       rd_vld_q;
    logic [7:0] rd_data_q;
    logic       on_q;
    logic       blon_q;

    logic       unused_bits;

    // {RW, RS, DATA}; bit 8 and the middle of the word carry nothing here
    assign in_word     = {bus.i_lcd[10], bus.i_lcd[9], bus.i_lcd[7:0]};
    assign unused_bits = ^{bus.i_lcd[29:11], bus.i_lcd[8]};

    assign done    = (cnt == '0);
    assign is_long = !act_rs && (act_data[7:2] == 6'd0) && (act_data[1:0] != 2'd0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt - CW'(1);
        take_new  = 1'b0;
        take_pend = 1'b0;
        finish    = 1'b0;
        cap       = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = cnt;
                if (bus.i_lcd_vld) begin
                    take_new  = 1'b1;
                    state_nxt = SETUP;
                    cnt_nxt   = LD_SETUP;
                end
            end
            SETUP: begin
                if (done) begin
                    state_nxt = PULSE;
                    cnt_nxt   = LD_PULSE;
                end
            end
            PULSE: begin
                if (done) begin
                    state_nxt = HOLD;
                    cnt_nxt   = LD_HOLD;
                    cap       = act_rw;
                end
            end
            HOLD: begin
                if (done) begin
                    if (act_rw) begin
                        finish = 1'b1;
                    end else begin
                        state_nxt = EXEC;
                        cnt_nxt   = is_long ? LD_LONG : LD_SHORT;
                    end
                end
            end
            EXEC: begin
                if (done) begin
                    finish = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        // A queued word starts straight away, so back-to-back cycles have no IDLE gap
        if (finish) begin
            if (pend_vld) begin
                take_pend = 1'b1;
                state_nxt = SETUP;
                cnt_nxt   = LD_SETUP;
            end else begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        end
    end

`ifdef LCD_CTRL_PENDING_EN
    logic [9:0] pend_word;
    logic       store;

    // The slot freed by take_pend can absorb a write landing in that same cycle
    assign store = bus.i_lcd_vld && (state != IDLE) && (!pend_vld || take_pend);
    assign drop  = bus.i_lcd_vld && (state != IDLE) && !store;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pend_vld  <= 1'b0;
            pend_word <= '0;
        end else if (store) begin
            pend_vld  <= 1'b1;
            pend_word <= in_word;
        end else if (take_pend) begin
            pend_vld  <= 1'b0;
        end
    end
`else
    logic [9:0] pend_word;

    assign pend_vld  = 1'b0;
    assign pend_word = '0;
    assign drop      = bus.i_lcd_vld && (state != IDLE);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            act_data  <= '0;
            act_rs    <= 1'b0;
            act_rw    <= 1'b0;
            drop_q    <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            on_q      <= 1'b0;
            blon_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            drop_q   <= drop;
            rd_vld_q <= cap;
            if (take_new) begin
                {act_rw, act_rs, act_data} <= in_word;
            end else if (take_pend) begin
                {act_rw, act_rs, act_data} <= pend_word;
            end
            if (cap) begin
                rd_data_q <= bus.i_lcd_data;
            end
            if (bus.i_lcd_vld) begin
                on_q   <= bus.i_lcd[31];
                blon_q <= bus.i_lcd[30];
            end
        end
    end

    assign drive = (state == SETUP) || (state == PULSE) || (state == HOLD);

    assign bus.o_lcd_en      = (state == PULSE);
    assign bus.o_lcd_rs      = drive && act_rs;
    assign bus.o_lcd_rw      = drive && act_rw;
    assign bus.o_lcd_data    = drive ? act_data : 8'd0;
    assign bus.o_lcd_data_oe = drive && !act_rw;
    assign bus.o_lcd_on      = on_q;
    assign bus.o_lcd_blon    = blon_q;
    assign bus.o_busy        = (state != IDLE) || pend_vld;
    assign bus.o_drop        = drop_q;
    assign bus.o_rd_data     = rd_data_q;
    assign bus.o_rd_vld      = rd_vld_q;

endmodule
